// File: rtl/serial_sequencer_if.sv
// Start/opcode handshake and control-word bundle for the serial sequencer.
// The core keeps flat ports so existing parents still connect unchanged.
interface serial_sequencer_if #(
  parameter int CW = 3
);
  logic [2:0]    i_instr;
  logic          i_start;
  logic [CW-1:0] o_con_bitsel;
  logic          o_con_mux;
  logic          o_con_muxalu;
  logic [1:0]    o_con_aluop;
  logic          o_con_carry_init;
  logic          o_con_gpr_region;
  logic          o_con_gpr_write;
  logic          o_con_gpr_shift;
  logic          o_con_pcincr;
  logic          o_busy;
  logic          o_done;
  logic          o_illegal;
  logic          o_halted;

  modport master (
    output i_instr, i_start,
    input  o_con_bitsel, o_con_mux, o_con_muxalu, o_con_aluop, o_con_carry_init,
           o_con_gpr_region, o_con_gpr_write, o_con_gpr_shift, o_con_pcincr,
           o_busy, o_done, o_illegal, o_halted
  );

  modport slave (
    input  i_instr, i_start,
    output o_con_bitsel, o_con_mux, o_con_muxalu, o_con_aluop, o_con_carry_init,
           o_con_gpr_region, o_con_gpr_write, o_con_gpr_shift, o_con_pcincr,
           o_busy, o_done, o_illegal, o_halted
  );
endinterface

// File: rtl/serial_sequencer.sv
// Bit-serial instruction sequencer: steps a GPR/ALU datapath one bit per cycle
// through FETCH (operand B into accumulator) and EXEC (write back) phases.
module serial_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [2:0]    i_instr,
  input  logic          i_start,
  output logic [CW-1:0] o_con_bitsel,
  output logic          o_con_mux,
  output logic          o_con_muxalu,
  output logic [1:0]    o_con_aluop,
  output logic          o_con_carry_init,
  output logic          o_con_gpr_region,
  output logic          o_con_gpr_write,
  output logic          o_con_gpr_shift,
  output logic          o_con_pcincr,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_illegal,
  output logic          o_halted
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, DONE, HALTED} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ILL, OP_HALT
  } op_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state, state_nx;
  op_t           op, op_nx;
  logic [CW-1:0] cnt, cnt_nx;

  function automatic logic [1:0] alu_code(input op_t o);
    case (o)
      OP_SUB:  return 2'b01;
      OP_AND:  return 2'b10;
      OP_OR:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    op_nx    = op;
    cnt_nx   = '0;
    case (state)
      IDLE: begin
        if (i_start) begin
          op_nx = op_t'(i_instr);
          case (op_t'(i_instr))
            OP_NOP, OP_ILL: state_nx = DONE;
            OP_LOAD:        state_nx = EXEC;
            OP_HALT:        state_nx = HALTED;
            default:        state_nx = FETCH;
          endcase
        end
      end
      FETCH: begin
        if (cnt == LAST) state_nx = EXEC;
        else             cnt_nx   = cnt + 1'b1;
      end
      EXEC: begin
        if (cnt == LAST) state_nx = DONE;
        else             cnt_nx   = cnt + 1'b1;
      end
      DONE:    state_nx = IDLE;
      HALTED:  state_nx = HALTED;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      op               <= OP_NOP;
      cnt              <= '0;
      o_con_bitsel     <= '0;
      o_con_mux        <= 1'b0;
      o_con_muxalu     <= 1'b0;
      o_con_aluop      <= 2'b00;
      o_con_carry_init <= 1'b0;
      o_con_gpr_region <= 1'b0;
      o_con_gpr_write  <= 1'b0;
      o_con_gpr_shift  <= 1'b0;
      o_con_pcincr     <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_illegal        <= 1'b0;
      o_halted         <= 1'b0;
    end else begin
      state            <= state_nx;
      op               <= op_nx;
      cnt              <= cnt_nx;
      o_con_bitsel     <= cnt_nx;
      o_con_mux        <= (state_nx == EXEC) && (op_nx == OP_LOAD);
      o_con_muxalu     <= (state_nx == FETCH);
      o_con_aluop      <= (state_nx == FETCH || state_nx == EXEC) ? alu_code(op_nx) : 2'b00;
      o_con_carry_init <= (state_nx == EXEC) && (cnt_nx == '0) && (op_nx == OP_SUB);
      o_con_gpr_region <= (state_nx == FETCH);
      o_con_gpr_write  <= (state_nx == EXEC);
      o_con_gpr_shift  <= (state_nx == FETCH || state_nx == EXEC);
      o_con_pcincr     <= (state_nx == DONE);
      o_busy           <= (state_nx == FETCH || state_nx == EXEC || state_nx == DONE);
      o_done           <= (state_nx == DONE);
      o_illegal        <= (state_nx == DONE) && (op_nx == OP_ILL);
      o_halted         <= (state_nx == HALTED);
    end
  end

endmodule

// File: tb/tb_serial_sequencer.sv
// Bench for serial_sequencer: WIDTH=8 and WIDTH=5 instances checked cycle by
// cycle against a cycle-index model of the instruction timeline.
module tb_serial_sequencer;

  typedef logic [15:0] vec_t;

  typedef struct {
    bit         five;
    logic [2:0] op;
    int         done_cyc;
    logic       ill;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic ill;
  rec_t tbl [8];

  always #5 clk = ~clk;

  serial_sequencer_if #(.CW(3)) bus8 ();
  serial_sequencer_if #(.CW(3)) bus5 ();

  serial_sequencer #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(bus8.i_instr), .i_start(bus8.i_start),
    .o_con_bitsel(bus8.o_con_bitsel), .o_con_mux(bus8.o_con_mux),
    .o_con_muxalu(bus8.o_con_muxalu), .o_con_aluop(bus8.o_con_aluop),
    .o_con_carry_init(bus8.o_con_carry_init), .o_con_gpr_region(bus8.o_con_gpr_region),
    .o_con_gpr_write(bus8.o_con_gpr_write), .o_con_gpr_shift(bus8.o_con_gpr_shift),
    .o_con_pcincr(bus8.o_con_pcincr), .o_busy(bus8.o_busy), .o_done(bus8.o_done),
    .o_illegal(bus8.o_illegal), .o_halted(bus8.o_halted)
  );

  serial_sequencer #(.WIDTH(5)) u_dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(bus5.i_instr), .i_start(bus5.i_start),
    .o_con_bitsel(bus5.o_con_bitsel), .o_con_mux(bus5.o_con_mux),
    .o_con_muxalu(bus5.o_con_muxalu), .o_con_aluop(bus5.o_con_aluop),
    .o_con_carry_init(bus5.o_con_carry_init), .o_con_gpr_region(bus5.o_con_gpr_region),
    .o_con_gpr_write(bus5.o_con_gpr_write), .o_con_gpr_shift(bus5.o_con_gpr_shift),
    .o_con_pcincr(bus5.o_con_pcincr), .o_busy(bus5.o_busy), .o_done(bus5.o_done),
    .o_illegal(bus5.o_illegal), .o_halted(bus5.o_halted)
  );

  // {bitsel[15:13], mux, muxalu, aluop[10:9], carry, region, write, shift, pcincr, busy, done, illegal, halted}
  vec_t got8, got5;
  assign got8 = {bus8.o_con_bitsel, bus8.o_con_mux, bus8.o_con_muxalu, bus8.o_con_aluop,
                 bus8.o_con_carry_init, bus8.o_con_gpr_region, bus8.o_con_gpr_write,
                 bus8.o_con_gpr_shift, bus8.o_con_pcincr, bus8.o_busy, bus8.o_done,
                 bus8.o_illegal, bus8.o_halted};
  assign got5 = {bus5.o_con_bitsel, bus5.o_con_mux, bus5.o_con_muxalu, bus5.o_con_aluop,
                 bus5.o_con_carry_init, bus5.o_con_gpr_region, bus5.o_con_gpr_write,
                 bus5.o_con_gpr_shift, bus5.o_con_pcincr, bus5.o_busy, bus5.o_done,
                 bus5.o_illegal, bus5.o_halted};

  function automatic vec_t mk(input int bs, input int mux, input int muxalu, input int aluop,
                              input int carry, input int region, input int wr, input int sh,
                              input int pc, input int busy, input int done, input int il,
                              input int halted);
    return {3'(bs), 1'(mux), 1'(muxalu), 2'(aluop), 1'(carry), 1'(region), 1'(wr),
            1'(sh), 1'(pc), 1'(busy), 1'(done), 1'(il), 1'(halted)};
  endfunction

  function automatic int exp_len(input int w, input logic [2:0] op);
    if (op == 3'b000 || op == 3'b110) return 1;
    if (op == 3'b001) return w + 1;
    return 2 * w + 1;
  endfunction

  // Expected outputs during cycle k after the start edge (k=1 is the first cycle).
  function automatic vec_t exp_vec(input int w, input logic [2:0] op, input int k);
    int a;
    case (op)
      3'b011:  a = 1;
      3'b100:  a = 2;
      3'b101:  a = 3;
      default: a = 0;
    endcase
    if (op == 3'b111) return mk(0,0,0,0,0,0,0,0,0,0,0,0,1);
    if (k == exp_len(w, op)) return mk(0,0,0,0,0,0,0,0,1,1,1,(op == 3'b110) ? 1 : 0,0);
    if (op == 3'b001 && k >= 1 && k <= w) return mk(k-1,1,0,0,0,0,1,1,0,1,0,0,0);
    if (op >= 3'b010 && op <= 3'b101) begin
      if (k >= 1 && k <= w) return mk(k-1,0,1,a,0,1,0,1,0,1,0,0,0);
      if (k > w && k <= 2 * w)
        return mk(k-w-1,0,0,a,(op == 3'b011 && k == w + 1) ? 1 : 0,0,1,1,0,1,0,0,0);
    end
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input bit five, input logic s, input logic [2:0] ins);
    if (five) begin bus5.i_start = s; bus5.i_instr = ins; end
    else      begin bus8.i_start = s; bus8.i_instr = ins; end
  endtask

  // Called just after a falling edge; returns just after a falling edge in IDLE.
  task automatic run(input bit five, input logic [2:0] op, input bit hold, input bit noisy,
                     input int exp_done, output logic ill_at_done);
    int   w, n, first;
    vec_t g;
    w = five ? 5 : 8;
    n = exp_len(w, op);
    first = 0;
    ill_at_done = 1'b0;
    drive(five, 1'b1, op);
    for (int k = 1; k <= n + 1; k++) begin
      @(posedge clk); #1;
      g = five ? got5 : got8;
      chk($sformatf("w%0d op%0d cyc%0d", w, op, k), g, exp_vec(w, op, k));
      if (g[2] && first == 0) begin
        first = k;
        ill_at_done = g[1];
      end
      @(negedge clk);
      if (k >= n)     drive(five, hold, op);
      else if (noisy) drive(five, 1'($urandom), 3'($urandom));
      else            drive(five, 1'b0, op);
    end
    chk($sformatf("done_cycle w%0d op%0d", w, op), first, exp_done);
  endtask

  initial begin
    tbl[0] = '{1'b0, 3'b110,  1, 1'b1};
    tbl[1] = '{1'b0, 3'b000,  1, 1'b0};
    tbl[2] = '{1'b0, 3'b001,  9, 1'b0};
    tbl[3] = '{1'b0, 3'b011, 17, 1'b0};
    tbl[4] = '{1'b0, 3'b010, 17, 1'b0};
    tbl[5] = '{1'b0, 3'b100, 17, 1'b0};
    tbl[6] = '{1'b0, 3'b101, 17, 1'b0};
    tbl[7] = '{1'b1, 3'b010, 11, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b000);
    drive(1'b1, 1'b0, 3'b000);
    #12;
    chk("reset8", got8, '0);
    chk("reset5", got5, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start", got8, '0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run(tbl[i].five, tbl[i].op, 1'b0, 1'b0, tbl[i].done_cyc, ill);
      chk($sformatf("illegal_flag op%0d", tbl[i].op), ill, tbl[i].ill);
    end

    for (int i = 0; i < 30; i++) begin
      logic [2:0] op;
      bit         five;
      op   = 3'($urandom_range(0, 6));
      five = 1'($urandom);
      run(five, op, 1'b0, 1'b1, exp_len(five ? 5 : 8, op), ill);
    end

    // Start held high: second ADD's first FETCH lands 13 cycles after the first start.
    run(1'b1, 3'b010, 1'b1, 1'b0, 11, ill);
    run(1'b1, 3'b010, 1'b0, 1'b0, 11, ill);

    // Reset during EXEC bit 3, then a fresh ADD.
    drive(1'b0, 1'b1, 3'b010);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("pre_abort cyc%0d", k), got8, exp_vec(8, 3'b010, k));
      @(negedge clk);
      drive(1'b0, 1'b0, 3'b010);
    end
    #2 rst_n = 1'b0;
    #1 chk("async_abort", got8, '0);
    @(posedge clk); #1;
    chk("abort_held", got8, '0);
    @(negedge clk); rst_n = 1'b1;
    run(1'b0, 3'b010, 1'b0, 1'b0, 17, ill);

    // HALT: sticky until reset, starts ignored.
    drive(1'b0, 1'b1, 3'b111);
    @(posedge clk); #1;
    chk("halt_enter", got8, exp_vec(8, 3'b111, 1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b0, 1'($urandom), 3'($urandom));
      @(posedge clk); #1;
      chk($sformatf("halt_hold %0d", i), got8, exp_vec(8, 3'b111, 1));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000);
    rst_n = 1'b0;
    #1 chk("halt_reset", got8, '0);
    @(negedge clk); rst_n = 1'b1;
    run(1'b0, 3'b000, 1'b0, 1'b0, 1, ill);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_sequencer.md
SERIAL_SEQUENCER -- requirements
Module: serial_sequencer

Interface
REQ-001 Parameter: WIDTH, 8, operand length in bits; SHALL be >= 2.
REQ-002 Parameter: CW, $clog2(WIDTH), bit-counter width (derived, not overridden).
REQ-003 Ports: one clock; reset is asynchronous and active-low; the ports SHALL be named i_clk and i_rst_n.
REQ-004 The ports SHALL be exactly as follows:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  async active-low reset
- i_instr  input  3  opcode, sampled on start
- i_start  input  1  begin instruction, honoured only in IDLE
- o_con_bitsel  output  CW  current bit index
- o_con_mux  output  1  select switch input to GPR
- o_con_muxalu  output  1  select GPR into accumulator
- o_con_aluop  output  2  00 ADD, 01 SUB, 10 AND, 11 OR
- o_con_carry_init  output  1  serial carry seed
- o_con_gpr_region  output  1  operand-B region select
- o_con_gpr_write  output  1  GPR write enable
- o_con_gpr_shift  output  1  GPR shift enable
- o_con_pcincr  output  1  advance PC
- o_busy  output  1  instruction in progress
- o_done  output  1  completion pulse
- o_illegal  output  1  illegal-opcode pulse
- o_halted  output  1  HALT executed

Function
REQ-005 Opcodes SHALL be: 000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 illegal, 111 HALT.
REQ-006 States SHALL be IDLE, FETCH, EXEC, DONE and HALTED, held in registered state; no combinational state storage.
REQ-007 IDLE with i_start=1 SHALL latch i_instr into an opcode register and clear the counter.
- NOP or 110: go to DONE.
- LOAD: go to EXEC.
- ADD/SUB/AND/OR: go to FETCH.
- HALT: go to HALTED.
REQ-008 IDLE with i_start=0: remain in IDLE; all control outputs 0.
REQ-009 FETCH: muxalu=1, gpr_region=1, gpr_shift=1, for exactly WIDTH cycles; at count==WIDTH-1 go to EXEC with count reset to 0.
REQ-010 EXEC, LOAD: mux=1, gpr_region=0, gpr_write=1, gpr_shift=1.
REQ-011 EXEC, ALU ops: mux=0, muxalu=0, gpr_region=0, gpr_write=1, gpr_shift=1, aluop from opcode.
REQ-012 EXEC SHALL last exactly WIDTH cycles; at count==WIDTH-1 go to DONE with count reset to 0.
REQ-013 carry_init SHALL be 1 only in EXEC, count==0, opcode SUB; 0 otherwise.
REQ-014 aluop SHALL hold the latched value during FETCH and EXEC; 00 elsewhere.
REQ-015 Counter SHALL increment by 1 each cycle in FETCH/EXEC and be 0 elsewhere; o_con_bitsel SHALL equal the counter; counter SHALL never exceed WIDTH-1, including non-power-of-2 WIDTH.
REQ-016 DONE SHALL last one cycle: pcincr=1, done=1; illegal=1 if latched opcode 110; then go to IDLE.
REQ-017 o_busy SHALL be 1 in FETCH, EXEC and DONE, and 0 in IDLE and HALTED.
REQ-018 i_start and i_instr SHALL be ignored outside IDLE; i_instr changes mid-instruction SHALL not affect the sequence.
REQ-019 HALTED: all control outputs 0, o_halted=1; leave only on reset.
REQ-020 Latency from the start edge: NOP = DONE at cycle 1; LOAD = EXEC cycles 1..WIDTH, DONE at WIDTH+1; ALU = FETCH 1..WIDTH, EXEC WIDTH+1..2*WIDTH, DONE at 2*WIDTH+1.
REQ-021 i_start held high continuously SHALL start a new instruction at the first IDLE cycle after DONE; back-to-back spacing is one IDLE cycle.

Reset
REQ-022 i_rst_n low SHALL immediately force the following, independent of i_clk:
- state IDLE
- counter 0
- opcode register 000
- all outputs 0
REQ-023 Reset asserted mid-FETCH/EXEC SHALL abort with no pcincr or done pulse; first start after release SHALL run a full sequence.

Verification
REQ-024 WIDTH=8, start with LOAD -> write/shift/mux high for 8 cycles, bitsel 0..7, pcincr+done at cycle 9.
REQ-025 WIDTH=8, SUB -> 8 FETCH cycles (region=1), 8 EXEC cycles (aluop=01, carry_init only at first), done at cycle 17.
REQ-026 Opcode 110 -> DONE at cycle 1 with illegal=1, pcincr=1, no write/shift; then NOP -> done with illegal=0.
REQ-027 WIDTH=5, ADD with i_start held high -> bitsel 0..4 twice, done at cycle 11, next instruction FETCH begins cycle 13.
REQ-028 Reset pulsed at EXEC count 3 -> outputs 0 asynchronously, no done; re-start ADD completes normally.
REQ-029 HALT -> o_halted=1, busy=0, further starts ignored for 20 cycles; reset clears o_halted.
